// File: rtl/mcp23s17_pkg.sv
// Shared types and constants for the MCP23S17 SPI master controller.
// Register constants are used by the bench and by software documentation.
package mcp23s17_pkg;

  typedef enum logic [2:0] {
    CS_IDLE  = 3'd0,
    CS_SETUP = 3'd1,
    SCK_LOW  = 3'd2,
    SCK_HIGH = 3'd3,
    CS_HOLD  = 3'd4,
    CS_GAP   = 3'd5
  } CtrlState;

  localparam logic [3:0] OPC_BASE   = 4'b0100;
  localparam int         FRAME_BITS = 24;

  localparam logic [7:0] IOCON = 8'h0A;
  localparam logic [7:0] IODIR = 8'h0F;

endpackage

// File: rtl/cdc_synchron.sv
// Multi-stage flop synchroniser for a single asynchronous input bit.
module CDCSynchron #(
  parameter int STAGES = 2
) (
  input  logic sysClk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_r[STAGES-1];

endmodule

// File: rtl/mcp23s17_master_ctrl_phase_timer.sv
// Phase timer: counts down CLK_DIV cycles per FSM state, flagging the last cycle.
module SpiPhaseTimer #(
  parameter int CLK_DIV = 4
) (
  input  logic sysClk,
  input  logic reset,
  input  logic load_i,
  output logic phase_end_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Reload on each state change, otherwise count down and park at zero.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      cnt_r <= RELOAD;
    end else if (load_i) begin
      cnt_r <= RELOAD;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign phase_end_o = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mcp23s17_master_ctrl.sv
// SPI mode-0 master that frames one 3-byte MCP23S17 register access per start pulse.
// Reads return the third received byte on rd_data_o.
module mcp23s17_master_ctrl
  import mcp23s17_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [2:0] HW_ADDR = 3'b000
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rd_data_o,
  output logic       spiClk_o,
  output logic       cs_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  generate
    if (CLK_DIV < 4) begin : g_bad_clk_div
      $error("CLK_DIV must be at least 4 for the slave synchronisers");
    end
  endgenerate

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  CtrlState    state_r;
  logic [23:0] tx_r;
  logic [7:0]  rx_r;
  logic [4:0]  bit_cnt_r;
  logic        rw_r;
  logic [23:0] frame_s;
  logic        load_s;
  logic        phase_end_s;
  logic        miso_sync_s;

  SpiPhaseTimer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .sysClk      (sysClk),
    .reset       (reset),
    .load_i      (load_s),
    .phase_end_o (phase_end_s)
  );

  CDCSynchron #(.STAGES(2)) u_miso_sync (
    .sysClk  (sysClk),
    .reset   (reset),
    .async_i (miso_i),
    .sync_o  (miso_sync_s)
  );

  // Timer is held loaded in IDLE so the first phase starts at full length.
  always_comb begin
    load_s = 1'b0;
    if (state_r == CS_IDLE) begin
      load_s = 1'b1;
    end else begin
      load_s = phase_end_s;
    end
  end

  // Assemble opcode, address and data; reads clock out a zero data byte.
  always_comb begin
    frame_s = {OPC_BASE, HW_ADDR, rw_i, reg_addr_i, 8'h00};
    if (!rw_i) begin
      frame_s[7:0] = wr_data_i;
    end else begin
      frame_s[7:0] = 8'h00;
    end
  end

  // Transaction FSM with registered bus and handshake outputs.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state_r   <= CS_IDLE;
      tx_r      <= 24'h000000;
      rx_r      <= 8'h00;
      bit_cnt_r <= 5'd0;
      rw_r      <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_data_o <= 8'h00;
      spiClk_o  <= 1'b0;
      cs_o      <= 1'b1;
      mosi_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        CS_IDLE: begin
          if (start_i) begin
            tx_r      <= frame_s;
            rw_r      <= rw_i;
            bit_cnt_r <= 5'd0;
            mosi_o    <= frame_s[23];
            cs_o      <= 1'b0;
            busy_o    <= 1'b1;
            state_r   <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (phase_end_s) begin
            state_r <= SCK_LOW;
          end
        end
        SCK_LOW: begin
          if (phase_end_s) begin
            spiClk_o <= 1'b1;
            state_r  <= SCK_HIGH;
          end
        end
        SCK_HIGH: begin
          if (phase_end_s) begin
            rx_r      <= {rx_r[6:0], miso_sync_s};
            tx_r      <= {tx_r[22:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 5'd1;
            spiClk_o  <= 1'b0;
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= CS_HOLD;
            end else begin
              // MOSI only changes on entry to SCK_LOW (mode 0 setup edge).
              mosi_o  <= tx_r[22];
              state_r <= SCK_LOW;
            end
          end
        end
        CS_HOLD: begin
          if (phase_end_s) begin
            cs_o   <= 1'b1;
            done_o <= 1'b1;
            if (rw_r) begin
              rd_data_o <= rx_r;
            end
            state_r <= CS_GAP;
          end
        end
        CS_GAP: begin
          if (phase_end_s) begin
            busy_o  <= 1'b0;
            state_r <= CS_IDLE;
          end
        end
        default: begin
          state_r  <= CS_IDLE;
          busy_o   <= 1'b0;
          spiClk_o <= 1'b0;
          cs_o     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp23s17_master_ctrl.sv
// Self-checking bench: table-driven transactions against a behavioural MCP23S17 slave,
// plus mid-frame reset and an alternate HW_ADDR/CLK_DIV instance.
module tb_mcp23s17_master_ctrl;
  import mcp23s17_pkg::*;

  localparam int D1 = 4;
  localparam int D2 = 6;

  logic       sysClk;
  logic       reset;
  logic       start_i, rw_i, start2;
  logic [7:0] reg_addr_i, wr_data_i;
  logic       busy_o, done_o, spiClk_o, cs_o, mosi_o, miso_i;
  logic [7:0] rd_data_o;
  logic       busy2, done2, sck2, cs2, mosi2;
  logic [7:0] rd2;

  mcp23s17_master_ctrl #(.CLK_DIV(D1), .HW_ADDR(3'b000)) dut (
    .sysClk(sysClk), .reset(reset), .start_i(start_i), .rw_i(rw_i),
    .reg_addr_i(reg_addr_i), .wr_data_i(wr_data_i), .busy_o(busy_o),
    .done_o(done_o), .rd_data_o(rd_data_o), .spiClk_o(spiClk_o),
    .cs_o(cs_o), .mosi_o(mosi_o), .miso_i(miso_i)
  );

  mcp23s17_master_ctrl #(.CLK_DIV(D2), .HW_ADDR(3'b101)) dut2 (
    .sysClk(sysClk), .reset(reset), .start_i(start2), .rw_i(rw_i),
    .reg_addr_i(reg_addr_i), .wr_data_i(wr_data_i), .busy_o(busy2),
    .done_o(done2), .rd_data_o(rd2), .spiClk_o(sck2),
    .cs_o(cs2), .mosi_o(mosi2), .miso_i(1'b1)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [23:0] frame;
    logic [7:0]  rd;
    logic        poke;
  } vec_t;

  typedef struct {
    logic [23:0] frame;
    logic [7:0]  rd;
  } exp_t;

  vec_t vecs [5];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Slave / bus-monitor state, all owned by the negedge process below.
  logic [7:0]  regs [256];
  logic [23:0] cap1, last_frame1, cap2, last_frame2;
  logic [7:0]  s_out;
  logic        sck_q, cs_q, sck2_q, cs2_q;
  int          s_cnt, last_bits1, frames1, hi_run2, last_hi2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Behavioural SPI slave (mode 0) and bus monitors, sampled away from the active edge.
  always @(negedge sysClk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      regs[IOCON] = 8'h28;
      regs[IODIR] = 8'hF9;
      miso_i = 1'b0;
      s_out  = 8'h00;
    end else begin
      if (!cs_o && cs_q) begin
        s_cnt = 0;
        cap1  = 24'h0;
      end
      if (!cs_o && spiClk_o && !sck_q) begin
        cap1 = {cap1[22:0], mosi_o};
        s_cnt++;
        if (s_cnt == 24 && !cap1[16]) regs[cap1[15:8]] = cap1[7:0];
      end
      if (!cs_o && !spiClk_o && sck_q && s_cnt >= 16 && s_cnt < 24) begin
        if (s_cnt == 16) s_out = regs[cap1[7:0]];
        miso_i = s_out[7];
        s_out  = {s_out[6:0], 1'b0};
      end
    end
    if (cs_o && !cs_q) begin
      frames1++;
      last_frame1 = cap1;
      last_bits1  = s_cnt;
    end
    sck_q = spiClk_o;
    cs_q  = cs_o;
    if (!cs2 && cs2_q) cap2 = 24'h0;
    if (!cs2 && sck2 && !sck2_q) cap2 = {cap2[22:0], mosi2};
    if (cs2 && !cs2_q) last_frame2 = cap2;
    if (sck2) hi_run2++;
    else if (sck2_q) begin
      last_hi2 = hi_run2;
      hi_run2  = 0;
    end
    sck2_q = sck2;
    cs2_q  = cs2;
  end

  // Drive one transaction on dut, called and returning on a negedge (returns in first IDLE cycle).
  task automatic run_txn(input vec_t v);
    int   f0, k, k_done, k_idle, n_done;
    exp_t e;
    f0 = frames1; k_done = -1; k_idle = -1; n_done = 0;
    e.frame = 24'h0; e.rd = 8'h00;
    rw_i = v.rw; reg_addr_i = v.addr; wr_data_i = v.wd; start_i = 1'b1;
    sb_q.push_back('{v.frame, v.rd});
    @(negedge sysClk); k = 1; start_i = 1'b0;
    chk("cs_low_T0+1", cs_o, 1'b0);
    chk("busy_T0+1", busy_o, 1'b1);
    while (k < 1 + 51 * D1 + 20 && k_idle < 0) begin
      @(negedge sysClk); k++;
      start_i = 1'b0;
      if (v.poke && k == 50) start_i = 1'b1;
      if (done_o) begin
        n_done++;
        if (k_done < 0) k_done = k;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rd_data_at_done", rd_data_o, e.rd);
        end
        if (v.poke) start_i = 1'b1;
      end
      if (!busy_o) k_idle = k;
    end
    start_i = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk("done_cycle", k_done, 1 + 50 * D1);
    chk("done_pulses", n_done, 1);
    chk("idle_cycle", k_idle, 1 + 51 * D1);
    chk("mosi_frame", last_frame1, e.frame);
    chk("frame_bits", last_bits1, 24);
    chk("cs_frames", frames1 - f0, 1);
  endtask

  initial begin
    int k, k_done, k_idle, n_done;
    vec_t wv;
    frames1 = 0; s_cnt = 0; last_bits1 = 0; hi_run2 = 0; last_hi2 = 0;
    cap1 = 24'h0; cap2 = 24'h0; last_frame1 = 24'h0; last_frame2 = 24'h0;
    sck_q = 1'b0; cs_q = 1'b1; sck2_q = 1'b0; cs2_q = 1'b1;
    reset = 1'b0; start_i = 1'b0; start2 = 1'b0; rw_i = 1'b0;
    reg_addr_i = 8'h00; wr_data_i = 8'h00;

    vecs[0] = '{1'b0, 8'h12, 8'hA5, 24'h4012A5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h0A, 8'h5A, 24'h410A00, 8'h28, 1'b0};
    vecs[2] = '{1'b1, 8'h0F, 8'h00, 24'h410F00, 8'hF9, 1'b0};
    vecs[3] = '{1'b0, 8'h12, 8'h3C, 24'h40123C, 8'hF9, 1'b1};
    vecs[4] = '{1'b1, 8'h12, 8'h00, 24'h411200, 8'h3C, 1'b0};

    repeat (3) @(negedge sysClk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_rd_data", rd_data_o, 8'h00);
    chk("rst_sck", spiClk_o, 1'b0);
    chk("rst_cs", cs_o, 1'b1);
    chk("rst_mosi", mosi_o, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge sysClk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Mid-frame reset at bit 10: outputs drop asynchronously, no done_o.
    rw_i = 1'b0; reg_addr_i = 8'h05; wr_data_i = 8'h77; start_i = 1'b1;
    @(negedge sysClk); start_i = 1'b0;
    k = 0;
    while (s_cnt < 10 && k < 200) begin
      @(negedge sysClk); k++;
    end
    chk("reached_bit10", (s_cnt >= 10), 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cs", cs_o, 1'b1);
    chk("midrst_sck", spiClk_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rd_data", rd_data_o, 8'h00);
    repeat (2) @(negedge sysClk);
    reset = 1'b1;
    n_done = 0;
    repeat (60) begin
      @(negedge sysClk);
      if (done_o || !cs_o) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    wv = '{1'b0, 8'h12, 8'h66, 24'h401266, 8'h00, 1'b0};
    run_txn(wv);

    // Alternate instance: HW_ADDR=5, CLK_DIV=6 read.
    rw_i = 1'b1; reg_addr_i = 8'h0F; start2 = 1'b1;
    @(negedge sysClk); k = 1; start2 = 1'b0;
    k_done = -1; k_idle = -1;
    while (k < 1 + 51 * D2 + 20 && k_idle < 0) begin
      @(negedge sysClk); k++;
      if (done2 && k_done < 0) begin
        k_done = k;
        chk("d2_rd_data", rd2, 8'hFF);
      end
      if (!busy2) k_idle = k;
    end
    chk("d2_done_cycle", k_done, 1 + 50 * D2);
    chk("d2_idle_cycle", k_idle, 1 + 51 * D2);
    chk("d2_mosi_frame", last_frame2, 24'h4B0F00);
    chk("d2_sck_half_period", last_hi2, D2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcp23s17_master_ctrl.md
# mcp23s17_master_ctrl

SPI master controller that sequences complete MCP23S17-style register transactions (opcode, register address, data) over a 4-wire SPI bus. It sits between the system-side logic (CPU or test sequencer) and the SPISlave/MCP23S17 port expander. A single start pulse produces one 3-byte chip-select-framed transfer in SPI mode 0, MSB first. On reads, the third received byte is returned.

## Interface
Parameters:
- CLK_DIV, 4: sysClk cycles per SCK half-period. Must be ≥ 4 so the slave's CDC synchronisers resolve each edge; elaboration-time error if smaller.
- HW_ADDR, 3'b000: device hardware address A2..A0, inserted into the opcode.

Ports:
- sysClk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request; accepted only in IDLE.
- rw_i  in  1  1 = read, 0 = write; sampled with start_i.
- reg_addr_i  in  8  register address; sampled with start_i.
- wr_data_i  in  8  write data; sampled with start_i, ignored on reads.
- busy_o  out  1  high from the cycle after acceptance until the controller returns to IDLE.
- done_o  out  1  one-cycle completion pulse.
- rd_data_o  out  8  last read result; held until the next read completes.
- spiClk_o  out  1  SCK; idles low.
- cs_o  out  1  /CS; active low.
- mosi_o  out  1  serial data to the slave.
- miso_i  in  1  serial data from the slave. Asynchronous; passes through a 2-flop synchroniser before sampling.

## Operation
- The state machine has six states: IDLE → CS_SETUP → SCK_LOW ⇄ SCK_HIGH → CS_HOLD → CS_GAP → IDLE.
- Every non-IDLE state lasts exactly CLK_DIV cycles, timed by a phase timer.
- Frame contents:
  - Opcode byte: {4'b0100, HW_ADDR, rw}, i.e. 0x40 for write and 0x41 for read when HW_ADDR = 0.
  - Byte 1: reg_addr.
  - Byte 2: wr_data on writes, 0x00 on reads.
- IDLE: cs_o=1, spiClk_o=0. When start_i=1, latch rw, reg_addr and wr_data into a 24-bit tx shift register, clear the bit counter, and go to CS_SETUP.
- CS_SETUP: cs_o=0, spiClk_o=0; mosi_o = tx[23].
- SCK_LOW: spiClk_o=0; mosi_o holds the current bit, which changes only on entry to SCK_LOW.
- SCK_HIGH: spiClk_o=1. In the last cycle of the phase:
  - shift synchronised miso into the 8-bit rx register;
  - shift tx left;
  - increment the 5-bit bit counter (0..23).
- After SCK_HIGH, go to SCK_LOW if the bit counter < 24, otherwise to CS_HOLD.
- CS_HOLD: spiClk_o=0, cs_o=0.
- CS_GAP: cs_o=1. In the first CS_GAP cycle:
  - done_o=1;
  - if the transfer was a read, rd_data_o is loaded from the rx register.
- Boundary conditions:
  - start_i while busy is ignored; there is no queueing.
  - A start_i arriving in the same cycle as done_o is ignored. The earliest accepted start is the first IDLE cycle.
  - Asserting reset mid-frame immediately forces all outputs to their reset values and returns to IDLE. The partial frame is abandoned and no done_o is produced.
  - Writes leave rd_data_o unchanged.
- Reset values: busy_o=0, done_o=0, rd_data_o=8'h00, spiClk_o=0, cs_o=1, mosi_o=0, state=IDLE.

## Timing
- Let T0 be the acceptance cycle (start_i=1 in IDLE).
- T0+1: cs_o falls and busy_o rises.
- First SCK rising edge: T0+1+2·CLK_DIV.
- Bit n (n = 0..23) is sampled at T0+(3+2n)·CLK_DIV.
- done_o pulses at T0+1+50·CLK_DIV; rd_data_o is valid from that same cycle.
- busy_o falls at T0+1+51·CLK_DIV. With CLK_DIV=4: done at T0+201, IDLE at T0+205.
- /CS stays high for at least CLK_DIV cycles between frames.
- MISO sampling delay is 2 synchroniser cycles plus the slave's shift latency. This lands within the SCK_HIGH phase, so CLK_DIV ≥ 4 is sufficient.

## Structure
- Package mcp23s17_pkg:
  - typedef enum CtrlState {CS_IDLE, CS_SETUP, SCK_LOW, SCK_HIGH, CS_HOLD, CS_GAP};
  - localparams OPC_BASE=4'b0100, FRAME_BITS=24;
  - register constants IOCON=8'h0A, IODIR=8'h0F (documentation/tests only).
- One sub-module, SpiPhaseTimer:
  - down-counter of width $clog2(CLK_DIV), reloaded on every state change;
  - asserts phase_end_o in the last cycle of each phase.
- The MISO synchroniser reuses the existing CDCSynchron; only sync_o is used.

## Test plan
- Write: reg 0x12, data 0xA5, HW_ADDR=0, CLK_DIV=4 → bus monitor captures MOSI 0x40,0x12,0xA5 MSB first; done_o at T0+201; rd_data_o stays 0x00.
- Read against the SPISlave model: reg 0x0A → MOSI 0x41,0x0A,0x00; rd_data_o=0x28 at done_o.
- Read reg 0x0F against SPISlave → rd_data_o=0xF9; a following write leaves rd_data_o=0xF9.
- start_i pulsed at T0+50 and again in the done_o cycle → both ignored; exactly one /CS frame; next start accepted in the first IDLE cycle.
- Reset asserted mid-frame at bit 10 → cs_o=1, spiClk_o=0, busy_o=0 asynchronously; no done_o; a new write after release produces a clean full frame.
- HW_ADDR=3'b101, CLK_DIV=6 read → opcode 0x4B; SCK half-period 6 cycles; done_o at T0+301.
